ctrl_wb_lq: RTL and testbench

Parametrised write-back controller for the Thumb pipeline. It decodes the instruction in the WB stage and drives the register-file write address, enable and data-source select. LDR destinations are held in an in-order load queue until memory data returns, so loads no longer block WB. A per-register busy mask feeds hazard detection upstream.

---
 rtl/ctrl_wb_lq.sv | 148 ++++++++++++++
 tb/tb_ctrl_wb_lq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_wb_lq.sv
// Write-back controller for the Thumb pipeline: decodes the WB instruction, drives the
// register-file write port and tracks outstanding LDR destinations in an in-order load queue.
module ctrl_wb_lq #(
    parameter int NREGS    = 16,
    parameter int LQ_DEPTH = 4,
    parameter int SP_IDX   = 13,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(LQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      i_ir_wb,
    input  logic             i_ir_valid,
    output logic             o_stall,
    input  logic             i_ld_valid,
    output logic [AW-1:0]    o_addr_rd_r,
    output logic             o_registers_rd_en,
    output logic             o_rd_sel,
    output logic [NREGS-1:0] o_busy,
    output logic [CW-1:0]    o_lq_count,
    output logic             o_err
);

    localparam int PW = $clog2(LQ_DEPTH);

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_WRITER,
        CLS_LOAD
    } ir_class_e;

    ir_class_e        cls;
    logic [AW-1:0]    rd;
    logic             is_writer;
    logic             is_load;
    logic             accept;
    logic             enq;
    logic             deq;
    logic             empty;
    logic             full;
    logic [NREGS-1:0] busy_c;

    logic [AW-1:0]    q_mem [LQ_DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    addr_q;
    logic             en_q;
    logic             sel_q;
    logic             err_q;

    // Patterns are on ir[15:7]; the low bits are don't-care except where they carry rd.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cls = CLS_NOP;
        rd  = '0;
        casez (i_ir_wb)
            16'b0001_110?_????_????: begin cls = CLS_WRITER; rd = AW'(i_ir_wb[2:0]);  end
            16'b1011_0000_1???_????: begin cls = CLS_WRITER; rd = AW'(SP_IDX);        end
            16'b0010_0???_????_????: begin cls = CLS_WRITER; rd = AW'(i_ir_wb[10:8]); end
            16'b0100_0110_????_????: begin
                cls = CLS_WRITER;
                rd  = AW'({i_ir_wb[7], i_ir_wb[2:0]});
            end
            16'b0110_1???_????_????: begin cls = CLS_LOAD;   rd = AW'(i_ir_wb[2:0]);  end
            default: ;
        endcase
    end

    assign is_writer = (cls == CLS_WRITER);
    assign is_load   = (cls == CLS_LOAD);
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(LQ_DEPTH));

    // Busy mask covers only the live window [head, head+count) of the circular queue.
    always_comb begin
        logic [PW-1:0] idx;
        busy_c = '0;
        idx    = '0;
        for (int k = 0; k < LQ_DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                busy_c[q_mem[idx]] = 1'b1;
            end
        end
    end

    // A writer yields the single write port to returning load data and waits out WAW hazards.
    assign o_stall = i_ir_valid &
                     ((is_writer & (i_ld_valid | busy_c[rd])) |
                      (is_load & full & ~i_ld_valid));

    assign accept = i_ir_valid & ~o_stall;
    assign enq    = accept & is_load;
    assign deq    = i_ld_valid & ~empty;

    // NOTE: queue storage has no reset; head/tail/count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_mem[tail_q] <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (deq) begin
                head_q <= head_q + PW'(1);
            end
            if (enq) begin
                tail_q <= tail_q + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(deq);

            if (deq) begin
                addr_q <= q_mem[head_q];
                en_q   <= 1'b1;
                sel_q  <= 1'b1;
            end else if (accept & is_writer) begin
                addr_q <= rd;
                en_q   <= 1'b1;
                sel_q  <= 1'b0;
            end else begin
                addr_q <= '0;
                en_q   <= 1'b0;
                sel_q  <= 1'b0;
            end

            err_q <= i_ld_valid & empty;
        end
    end

    assign o_addr_rd_r       = addr_q;
    assign o_registers_rd_en = en_q;
    assign o_rd_sel          = sel_q;
    assign o_busy            = busy_c;
    assign o_lq_count        = count_q;
    assign o_err             = err_q;

endmodule

// File: tb/tb_ctrl_wb_lq.sv
// Self-checking bench for ctrl_wb_lq: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ctrl_wb_lq;

    localparam int NREGS    = 16;
    localparam int LQ_DEPTH = 4;
    localparam int SP_IDX   = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir_wb;
    logic        ir_valid;
    logic        ld_valid;
    logic        stall;
    logic [3:0]  addr;
    logic        en;
    logic        sel;
    logic [15:0] busy;
    logic [2:0]  count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int ref_q[$];

    ctrl_wb_lq #(
        .NREGS    (NREGS),
        .LQ_DEPTH (LQ_DEPTH),
        .SP_IDX   (SP_IDX)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_ir_wb           (ir_wb),
        .i_ir_valid        (ir_valid),
        .o_stall           (stall),
        .i_ld_valid        (ld_valid),
        .o_addr_rd_r       (addr),
        .o_registers_rd_en (en),
        .o_rd_sel          (sel),
        .o_busy            (busy),
        .o_lq_count        (count),
        .o_err             (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ir, input logic irv, input logic ldv);
        ir_wb    = ir;
        ir_valid = irv;
        ld_valid = ldv;
        #1;
    endtask

    // Reference decode: 0 = nop, 1 = register writer, 2 = load.
    task automatic ref_decode(input logic [15:0] ir, output int kind, output int rd);
        kind = 0;
        rd   = 0;
        if (ir[15:9] == 7'b0001110)        begin kind = 1; rd = int'(ir[2:0]); end
        else if (ir[15:7] == 9'b101100001) begin kind = 1; rd = SP_IDX; end
        else if (ir[15:11] == 5'b00100)    begin kind = 1; rd = int'(ir[10:8]); end
        else if (ir[15:8] == 8'b01000110)  begin kind = 1; rd = int'({ir[7], ir[2:0]}); end
        else if (ir[15:11] == 5'b01101)    begin kind = 2; rd = int'(ir[2:0]); end
    endtask

    function automatic logic [15:0] ref_busy();
        logic [15:0] m = '0;
        foreach (ref_q[i]) m[ref_q[i]] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        drive(16'h0000, 1'b0, 1'b0);
        repeat (2) tick();
        n_checks++;
        if ({addr, en, sel, err} !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h en=%b sel=%b err=%b, want all 0", addr, en, sel, err);
        end
        n_checks++;
        if ({count, busy} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_queue: got count=%0d busy=%h, want 0/0000", count, busy);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_add();
        drive(16'h1C4A, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL add_stall: got %b want 0", stall);
        end
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({addr, en, sel} !== {4'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_write: got addr=%0d en=%b sel=%b, want 2/1/0", addr, en, sel);
        end
        tick();
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++;
            $display("FAIL add_en_drop: got %b want 0", en);
        end
    endtask

    task automatic test_load();
        drive(16'h6803, 1'b1, 1'b0);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({busy, count, en} !== {16'h0008, 3'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL load_pending[%0d]: got busy=%h count=%0d en=%b, want 0008/1/0", c, busy, count, en);
            end
            if (c < 2) tick();
        end
        drive(16'h0000, 1'b0, 1'b1);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({addr, en, sel, busy, count} !== {4'd3, 1'b1, 1'b1, 16'h0000, 3'd0}) begin
            n_fail++;
            $display("FAIL load_return: got addr=%0d en=%b sel=%b busy=%h count=%0d, want 3/1/1/0000/0",
                     addr, en, sel, busy, count);
        end
    endtask

    task automatic test_queue_full();
        logic [15:0] ir;
        for (int i = 0; i < 4; i++) begin
            ir = 16'h6800 + 16'(i);
            drive(ir, 1'b1, 1'b0);
            tick();
        end
        n_checks++;
        if ({count, busy} !== {3'd4, 16'h000F}) begin
            n_fail++;
            $display("FAIL full_fill: got count=%0d busy=%h, want 4/000F", count, busy);
        end
        drive(16'h6804, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stall: got %b want 1", stall);
        end
        tick();
        n_checks++;
        if ({count, en} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_hold: got count=%0d en=%b, want 4/0", count, en);
        end
        drive(16'h6804, 1'b1, 1'b1);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL full_swap_stall: got %b want 0", stall);
        end
        tick();
        n_checks++;
        if ({count, addr, en, sel, busy} !== {3'd4, 4'd0, 1'b1, 1'b1, 16'h001E}) begin
            n_fail++;
            $display("FAIL full_swap: got count=%0d addr=%0d en=%b sel=%b busy=%h, want 4/0/1/1/001E",
                     count, addr, en, sel, busy);
        end
        drive(16'h0000, 1'b0, 1'b1);
        repeat (4) tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({count, busy} !== 19'h0) begin
            n_fail++;
            $display("FAIL full_drain: got count=%0d busy=%h, want 0/0000", count, busy);
        end
    endtask

    task automatic test_port_conflict();
        drive(16'h6806, 1'b1, 1'b0);
        tick();
        drive(16'h2105, 1'b1, 1'b1);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_stall: got %b want 1", stall);
        end
        tick();
        n_checks++;
        if ({addr, en, sel} !== {4'd6, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL conflict_load_wins: got addr=%0d en=%b sel=%b, want 6/1/1", addr, en, sel);
        end
        drive(16'h2105, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_release: got %b want 0", stall);
        end
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({addr, en, sel} !== {4'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL conflict_mov: got addr=%0d en=%b sel=%b, want 1/1/0", addr, en, sel);
        end
    endtask

    task automatic test_waw();
        drive(16'h6805, 1'b1, 1'b0);
        tick();
        drive(16'h2507, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (stall !== 1'b1) begin
                n_fail++;
                $display("FAIL waw_stall[%0d]: got %b want 1", c, stall);
            end
            tick();
            n_checks++;
            if ({en, busy} !== {1'b0, 16'h0020}) begin
                n_fail++;
                $display("FAIL waw_wait[%0d]: got en=%b busy=%h, want 0/0020", c, en, busy);
            end
        end
        drive(16'h2507, 1'b1, 1'b1);
        tick();
        n_checks++;
        if ({addr, en, sel, busy} !== {4'd5, 1'b1, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL waw_load_first: got addr=%0d en=%b sel=%b busy=%h, want 5/1/1/0000", addr, en, sel, busy);
        end
        drive(16'h2507, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_release: got %b want 0", stall);
        end
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({addr, en, sel} !== {4'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL waw_mov_second: got addr=%0d en=%b sel=%b, want 5/1/0", addr, en, sel);
        end
        tick();
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_idle: got en=%b want 0", en);
        end
    endtask

    task automatic test_err_empty();
        drive(16'h0000, 1'b0, 1'b1);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({err, en, count} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL err_pulse: got err=%b en=%b count=%0d, want 1/0/0", err, en, count);
        end
        tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        drive(16'h6801, 1'b1, 1'b0);
        tick();
        drive(16'h6802, 1'b1, 1'b0);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({count, busy} !== {3'd2, 16'h0006}) begin
            n_fail++;
            $display("FAIL rstmid_pending: got count=%0d busy=%h, want 2/0006", count, busy);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({count, busy, en} !== 20'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got count=%0d busy=%h en=%b, want 0/0000/0", count, busy, en);
        end
        tick();
        rst = 1'b1;
        drive(16'h0000, 1'b0, 1'b1);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({err, en} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_stale_load: got err=%b en=%b, want 1/0", err, en);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] ir;
        logic        irv;
        logic        ldv;
        int          kind;
        int          rd;
        logic        exp_stall;
        logic [3:0]  exp_addr;
        logic        exp_en;
        logic        exp_sel;
        logic        exp_err;
        logic [15:0] bmask;
        ref_q = {};
        for (int cyc = 0; cyc < 400; cyc++) begin
            case ($urandom_range(0, 6))
                0:       ir = {7'b0001110, 9'($urandom)};
                1:       ir = {9'b101100001, 7'($urandom)};
                2:       ir = {5'b00100, 11'($urandom)};
                3:       ir = {8'b01000110, 8'($urandom)};
                4, 5:    ir = {5'b01101, 11'($urandom)};
                default: ir = 16'($urandom);
            endcase
            irv = ($urandom_range(0, 3) != 0);
            ldv = ($urandom_range(0, 99) < 30);
            drive(ir, irv, ldv);

            ref_decode(ir, kind, rd);
            bmask = ref_busy();
            exp_stall = irv && ((kind == 1 && (ldv || bmask[rd])) ||
                                (kind == 2 && ref_q.size() == LQ_DEPTH && !ldv));
            n_checks++;
            if (stall !== exp_stall) begin
                n_fail++;
                $display("FAIL rand_stall cyc=%0d ir=%h: got %b want %b", cyc, ir, stall, exp_stall);
            end

            exp_err = ldv && (ref_q.size() == 0);
            if (ldv && ref_q.size() > 0) begin
                exp_addr = 4'(ref_q.pop_front());
                exp_en   = 1'b1;
                exp_sel  = 1'b1;
            end else if (irv && !exp_stall && kind == 1) begin
                exp_addr = 4'(rd);
                exp_en   = 1'b1;
                exp_sel  = 1'b0;
            end else begin
                exp_addr = 4'd0;
                exp_en   = 1'b0;
                exp_sel  = 1'b0;
            end
            if (irv && !exp_stall && kind == 2) ref_q.push_back(rd);

            tick();
            n_checks++;
            if ({addr, en, sel, err} !== {exp_addr, exp_en, exp_sel, exp_err}) begin
                n_fail++;
                $display("FAIL rand_wb cyc=%0d: got addr=%0d en=%b sel=%b err=%b want %0d/%b/%b/%b",
                         cyc, addr, en, sel, err, exp_addr, exp_en, exp_sel, exp_err);
            end
            n_checks++;
            if ({busy, count} !== {ref_busy(), 3'(ref_q.size())}) begin
                n_fail++;
                $display("FAIL rand_queue cyc=%0d: got busy=%h count=%0d want %h/%0d",
                         cyc, busy, count, ref_busy(), ref_q.size());
            end
        end
        drive(16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_queue_full();
        test_port_conflict();
        test_waw();
        test_err_empty();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
